load_run_controller: RTL and testbench

Sequencing controller between the host command decoder and the core. It turns the decoder's level-held fetch/start flags into single-cycle write strobes for the weight, input and instruction memories, then launches a run and tracks it to completion or timeout. It also blocks host writes while the core is running and reports protocol errors.

---
 rtl/load_run_controller.sv | 185 ++++++++++++++++++
 tb/tb_load_run_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/load_run_controller.sv
// load_run_controller: turns level-held host fetch/start flags into single-cycle
// memory write strobes, launches a core run and tracks it to done or timeout.
// Host writes are refused while the core runs; protocol misuse latches err.
module load_run_controller #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int RUN_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_w,
  input  logic              fetch_inp,
  input  logic              fetch_ins,
  input  logic              start,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              core_done,
  output logic              wmem_we,
  output logic              imem_we,
  output logic              insmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   ins_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Command type encoding; T_NONE also stands for "no command this cycle".
  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_W    = 2'd1;
  localparam logic [1:0] T_INP  = 2'd2;
  localparam logic [1:0] T_INS  = 2'd3;

  localparam logic [ADDR_W:0] INS_MAX  = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [15:0]     RUN_LAST = 16'(RUN_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [1:0]          prev_type_q;
  logic [ADDR_W-1:0]   prev_addr_q;
  logic                start_prev_q;
  logic [15:0]         run_cnt_q, run_cnt_d;
  logic [ADDR_W:0]     ins_count_q, ins_count_d;
  logic                err_q, err_d;
  logic                wmem_we_q, wmem_we_d;
  logic                imem_we_q, imem_we_d;
  logic                insmem_we_q, insmem_we_d;
  logic                core_start_q, core_start_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [1:0] flag_count;
  logic       multi_flag;
  logic [1:0] cmd_type;
  logic       new_cmd;
  logic       start_edge;
  logic       idle_like;
  logic       launch;
  logic       do_write;
  logic       timeout_hit;

  // Command decode, edge detection and the shared launch/write decisions.
  always_comb begin
    flag_count = 2'(fetch_w) + 2'(fetch_inp) + 2'(fetch_ins);
    multi_flag = (flag_count > 2'd1);
    cmd_type   = T_NONE;
    if (flag_count == 2'd1) begin
      if (fetch_w)        cmd_type = T_W;
      else if (fetch_inp) cmd_type = T_INP;
      else                cmd_type = T_INS;
    end
    new_cmd     = (cmd_type != T_NONE) &&
                  ((prev_type_q == T_NONE) || (prev_type_q != cmd_type) ||
                   (prev_addr_q != dma_address));
    start_edge  = start && !start_prev_q;
    idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    launch      = idle_like && start_edge && (ins_count_q != '0);
    // A start edge takes priority and swallows a simultaneous command.
    do_write    = idle_like && new_cmd && !start_edge;
    timeout_hit = (state_q == S_RUN) && !core_done && (run_cnt_q == RUN_LAST);
  end

  // State register plus all registered outputs and bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      prev_type_q  <= T_NONE;
      prev_addr_q  <= '0;
      start_prev_q <= 1'b0;
      run_cnt_q    <= '0;
      ins_count_q  <= '0;
      err_q        <= 1'b0;
      wmem_we_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      insmem_we_q  <= 1'b0;
      core_start_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_type_q  <= cmd_type;
      prev_addr_q  <= dma_address;
      start_prev_q <= start;
      run_cnt_q    <= run_cnt_d;
      ins_count_q  <= ins_count_d;
      err_q        <= err_d;
      wmem_we_q    <= wmem_we_d;
      imem_we_q    <= imem_we_d;
      insmem_we_q  <= insmem_we_d;
      core_start_q <= core_start_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state selection: launch, completion, timeout and write-out-of-DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (launch) state_d = S_RUN;
      S_RUN: begin
        if (core_done)        state_d = S_DONE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_DONE: begin
        if (launch)        state_d = S_RUN;
        else if (do_write) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: strobes, write bus, counters, error flag.
  always_comb begin
    wmem_we_d    = 1'b0;
    imem_we_d    = 1'b0;
    insmem_we_d  = 1'b0;
    core_start_d = launch;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ins_count_d  = ins_count_q;
    run_cnt_d    = run_cnt_q;
    err_d        = err_q;

    if (do_write) begin
      mem_addr_d  = dma_address;
      mem_wdata_d = data_in;
      case (cmd_type)
        T_W:     wmem_we_d   = 1'b1;
        T_INP:   imem_we_d   = 1'b1;
        T_INS:   insmem_we_d = 1'b1;
        default: ;
      endcase
      if ((cmd_type == T_INS) && (ins_count_q != INS_MAX))
        ins_count_d = ins_count_q + 1'b1;
    end

    if (launch)                 run_cnt_d = '0;
    else if (state_q == S_RUN)  run_cnt_d = run_cnt_q + 16'd1;

    if (multi_flag)                                        err_d = 1'b1;
    if (idle_like && start_edge && (ins_count_q == '0))    err_d = 1'b1;
    if ((state_q == S_RUN) && (new_cmd || start_edge))     err_d = 1'b1;
    if (timeout_hit)                                       err_d = 1'b1;
  end

  assign wmem_we    = wmem_we_q;
  assign imem_we    = imem_we_q;
  assign insmem_we  = insmem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_start = core_start_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign ins_count  = ins_count_q;

endmodule

// File: tb/tb_load_run_controller.sv
// Directed bench for load_run_controller with an 8-cycle run timeout.
module tb_load_run_controller;

  logic       clk = 1'b0;
  logic       reset, fetch_w, fetch_inp, fetch_ins, start, core_done;
  logic [3:0] dma_address;
  logic [7:0] data_in;
  logic       wmem_we, imem_we, insmem_we, core_start, busy, done, err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [4:0] ins_count;

  int checks   = 0;
  int failures = 0;
  int n_a, n_b;
  logic err_before;

  load_run_controller #(.ADDR_W(4), .DATA_W(8), .RUN_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .fetch_w(fetch_w), .fetch_inp(fetch_inp), .fetch_ins(fetch_ins),
    .start(start), .dma_address(dma_address), .data_in(data_in),
    .core_done(core_done),
    .wmem_we(wmem_we), .imem_we(imem_we), .insmem_we(insmem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_start(core_start),
    .busy(busy), .done(done), .err(err), .ins_count(ins_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-24s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; fetch_w = 0; fetch_inp = 0; fetch_ins = 0; start = 0; core_done = 0;
    dma_address = 0; data_in = 0;
    tick(); tick();
    chk("rst_strobes", {wmem_we, imem_we, insmem_we, core_start}, 0);
    chk("rst_status", {busy, done, err}, 0);
    chk("rst_ins_count", ins_count, 0);
    chk("rst_addr_data", {mem_addr, mem_wdata}, 0);
    reset = 0;

    // Held W flag writes once.
    fetch_w = 1; dma_address = 3; data_in = 8'hA5;
    n_a = 0; n_b = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        chk("w_first_we", wmem_we, 1);
        chk("w_addr_data", {mem_addr, mem_wdata}, {4'd3, 8'hA5});
      end
      n_a += int'(wmem_we);
      n_b += int'(imem_we) + int'(insmem_we) + int'(core_start);
    end
    chk("w_pulse_count", n_a, 1);
    chk("w_other_strobes", n_b, 0);
    fetch_w = 0; data_in = 8'h11;
    tick();
    chk("hold_addr_data", {mem_addr, mem_wdata}, {4'd3, 8'hA5});

    // Back-to-back distinct commands.
    fetch_w = 1; dma_address = 7; data_in = 8'h5A;
    tick();
    chk("b2b_first", {wmem_we, mem_addr}, {1'b1, 4'd7});
    dma_address = 8;
    tick();
    chk("b2b_second", {wmem_we, mem_addr}, {1'b1, 4'd8});
    fetch_w = 0;
    tick();
    chk("b2b_end", wmem_we, 0);

    // Start with no instructions loaded.
    start = 1;
    tick();
    chk("start0_err", err, 1);
    chk("start0_no_launch", {core_start, busy}, 0);
    start = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("reset_clears_err", err, 0);

    // Held INS flag with stepping address.
    fetch_ins = 1; n_a = 0;
    for (int a = 0; a < 3; a++) begin
      dma_address = a[3:0]; data_in = 8'h30 + a[7:0];
      for (int j = 0; j < 2; j++) begin
        tick();
        if (j == 0) chk($sformatf("ins_we_addr%0d", a), {insmem_we, mem_addr}, {1'b1, a[3:0]});
        n_a += int'(insmem_we);
      end
    end
    fetch_ins = 0;
    tick();
    chk("ins_pulse_count", n_a, 3);
    chk("ins_count_3", ins_count, 3);

    // Launch, blocked write in RUN, completion.
    start = 1;
    tick();
    chk("launch", {core_start, busy, done}, 3'b110);
    tick();
    chk("launch_pulse_end", {core_start, busy}, 2'b01);
    fetch_inp = 1; dma_address = 5;
    tick();
    chk("run_cmd_blocked", {imem_we, err}, 2'b01);
    tick();
    core_done = 1;
    tick();
    chk("core_done", {busy, done}, 2'b01);
    core_done = 0;
    tick();
    chk("done_held_no_write", {done, imem_we}, 2'b10);
    dma_address = 6;
    tick();
    chk("write_from_done", {imem_we, done, mem_addr}, {1'b1, 1'b0, 4'd6});
    fetch_inp = 0; start = 0;
    tick();

    // Timeout with core_done never asserted.
    reset = 1;
    tick();
    reset = 0; fetch_ins = 1; dma_address = 9;
    tick();
    fetch_ins = 0;
    tick();
    start = 1;
    tick();
    n_a = 0; err_before = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      n_a++;
      err_before = err;
      tick();
    end
    chk("to_busy_cycles", n_a, 8);
    chk("to_err_before", err_before, 0);
    chk("to_after", {busy, done, err}, 3'b001);
    start = 0;
    tick();

    // core_done on the last allowed cycle; start edge beats a simultaneous command.
    reset = 1;
    tick();
    reset = 0; fetch_ins = 1; dma_address = 2;
    tick();
    fetch_ins = 0;
    tick();
    fetch_w = 1; dma_address = 4; data_in = 8'hC3; start = 1;
    tick();
    chk("prio_launch", {core_start, wmem_we}, 2'b10);
    for (int i = 1; i < 8; i++) tick();
    chk("last_cycle_busy", {busy, err}, 2'b10);
    core_done = 1;
    tick();
    chk("done_on_timeout", {busy, done, err}, 3'b010);
    core_done = 0;
    tick();
    chk("prio_cmd_dropped", {wmem_we, done, mem_addr}, {1'b0, 1'b1, 4'd2});
    fetch_w = 0;

    // Two fetch flags at once.
    fetch_w = 1; fetch_ins = 1;
    tick();
    chk("multi_err", {err, wmem_we, insmem_we}, 3'b100);
    chk("multi_no_count", ins_count, 1);
    fetch_w = 0; fetch_ins = 0;

    // Relaunch from DONE, then reset on the third RUN cycle.
    start = 0;
    tick();
    start = 1;
    tick();
    chk("relaunch", {core_start, busy}, 2'b11);
    tick();
    tick();
    reset = 1;
    tick();
    chk("midrun_reset_outs", {wmem_we, imem_we, insmem_we, core_start, busy, done, err}, 0);
    chk("midrun_ins_count", ins_count, 0);
    reset = 0;
    tick();
    chk("held_start_after_rst", {core_start, busy, err}, 3'b001);
    fetch_ins = 1; dma_address = 1;
    tick();
    chk("ins_with_start_held", {insmem_we, core_start}, 2'b10);
    fetch_ins = 0;
    tick();
    tick();
    chk("held_start_no_launch", {core_start, busy}, 0);
    start = 0;
    tick();
    start = 1;
    tick();
    chk("fresh_launch", {core_start, busy}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
